xfer_bus_seq: RTL and testbench

- Sequencer for the shared 16-bit transfer bus and the bank of 16-bit up/down/load registers hanging off it (PC, SP, X, Y).
- Accepts one register-transfer command at a time through a valid/ready handshake. Expands it into per-register reg_write (bus drive), reg_load, inc and dec strobes.
- Guarantees a single bus driver per cycle. Sits between the decode stage and the register bank.

---
 rtl/xfer_bus_seq.sv | 236 +++++++++++++++++++++++
 tb/tb_xfer_bus_seq.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/xfer_bus_seq.sv
// Transfer-bus sequencer: expands one MOVE/INC/DEC/LDX command into per-register
// bus-drive, load and step strobes for the PC/SP/X/Y bank, one bus driver per cycle.

module xfer_bus_seq_chk #(
  parameter int N_REGS = 4
) (
  input logic              clk,
  input logic              reset_n,
  input logic [N_REGS-1:0] reg_write,
  input logic [N_REGS-1:0] reg_load,
  input logic [N_REGS-1:0] inc,
  input logic [N_REGS-1:0] dec,
  input logic              ext_oe,
  input logic              busy,
  input logic              done
);

  a_single_driver: assert property (@(posedge clk) disable iff (!reset_n)
    $onehot0({reg_write, ext_oe}));

  a_load_onehot: assert property (@(posedge clk) disable iff (!reset_n)
    $onehot0(reg_load));

  a_inc_dec_excl: assert property (@(posedge clk) disable iff (!reset_n)
    !((|inc) && (|dec)));

  a_quiet_when_idle: assert property (@(posedge clk) disable iff (!reset_n)
    busy || ({reg_write, reg_load, inc, dec, ext_oe} == '0));

  a_done_not_busy: assert property (@(posedge clk) disable iff (!reset_n)
    !(done && busy));

endmodule

module xfer_bus_seq #(
  parameter int N_REGS = 4,
  parameter int IDX_W  = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [IDX_W-1:0]  cmd_src,
  input  logic [IDX_W-1:0]  cmd_dst,
  input  logic [3:0]        cmd_cnt,
  input  logic [15:0]       cmd_data,
  output logic [N_REGS-1:0] reg_write,
  output logic [N_REGS-1:0] reg_load,
  output logic [N_REGS-1:0] inc,
  output logic [N_REGS-1:0] dec,
  output logic              ext_oe,
  output logic [15:0]       ext_data,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRIVE = 3'd1,
    S_LOAD  = 3'd2,
    S_STEP  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam logic [1:0] OP_MOVE = 2'b00;
  localparam logic [1:0] OP_INC  = 2'b01;
  localparam logic [1:0] OP_DEC  = 2'b10;
  localparam logic [1:0] OP_LDX  = 2'b11;

  function automatic logic [N_REGS-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [N_REGS-1:0] v;
    v = '0;
    for (int i = 0; i < N_REGS; i++) begin
      v[i] = (int'(idx) == i);
    end
    return v;
  endfunction

  function automatic logic idx_ok(input logic [IDX_W-1:0] idx);
    return (int'(idx) < N_REGS);
  endfunction

  state_e             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [IDX_W-1:0]   src_q, src_d;
  logic [IDX_W-1:0]   dst_q, dst_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [15:0]        ext_data_q, ext_data_d;
  logic [N_REGS-1:0]  reg_write_q, reg_write_d;
  logic [N_REGS-1:0]  reg_load_q, reg_load_d;
  logic [N_REGS-1:0]  inc_q, inc_d;
  logic [N_REGS-1:0]  dec_q, dec_d;
  logic               ext_oe_q, ext_oe_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               cmd_bad_s;

  // Out-of-range indices and self-moves collapse straight to DONE without touching the bus.
  assign cmd_bad_s = !idx_ok(cmd_dst) || ((cmd_op == OP_MOVE) && !idx_ok(cmd_src));

  // Next-state and command-latch logic
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    src_d      = src_q;
    dst_d      = dst_q;
    cnt_d      = cnt_q;
    ext_data_d = ext_data_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d       = cmd_op;
          src_d      = cmd_src;
          dst_d      = cmd_dst;
          cnt_d      = cmd_cnt;
          ext_data_d = cmd_data;
          if (cmd_bad_s || ((cmd_op == OP_MOVE) && (cmd_src == cmd_dst))) begin
            state_d = S_DONE;
          end else if ((cmd_op == OP_MOVE) || (cmd_op == OP_LDX)) begin
            state_d = S_DRIVE;
          end else begin
            state_d = S_STEP;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DRIVE: state_d = S_LOAD;
      S_LOAD:  state_d = S_DONE;
      S_STEP: begin
        if (cnt_q == 4'd0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes are decoded from the next state so they leave a flop in the same cycle the state does
  always_comb begin
    reg_write_d = '0;
    reg_load_d  = '0;
    inc_d       = '0;
    dec_d       = '0;
    ext_oe_d    = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    case (state_d)
      S_DRIVE, S_LOAD: begin
        busy_d = 1'b1;
        if (op_d == OP_LDX) begin
          ext_oe_d = 1'b1;
        end else begin
          reg_write_d = onehot(src_d);
        end
        if (state_d == S_LOAD) begin
          reg_load_d = onehot(dst_d);
        end else begin
          reg_load_d = '0;
        end
      end
      S_STEP: begin
        busy_d = 1'b1;
        if (op_d == OP_INC) begin
          inc_d = onehot(dst_d);
        end else if (op_d == OP_DEC) begin
          dec_d = onehot(dst_d);
        end else begin
          inc_d = '0;
        end
      end
      S_DONE:  done_d = 1'b1;
      default: done_d = 1'b0;
    endcase
  end

  // State, latched command and registered strobes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      op_q        <= 2'b00;
      src_q       <= '0;
      dst_q       <= '0;
      cnt_q       <= 4'd0;
      ext_data_q  <= 16'h0000;
      reg_write_q <= '0;
      reg_load_q  <= '0;
      inc_q       <= '0;
      dec_q       <= '0;
      ext_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      cnt_q       <= cnt_d;
      ext_data_q  <= ext_data_d;
      reg_write_q <= reg_write_d;
      reg_load_q  <= reg_load_d;
      inc_q       <= inc_d;
      dec_q       <= dec_d;
      ext_oe_q    <= ext_oe_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign reg_write = reg_write_q;
  assign reg_load  = reg_load_q;
  assign inc       = inc_q;
  assign dec       = dec_q;
  assign ext_oe    = ext_oe_q;
  assign ext_data  = ext_data_q;
  assign busy      = busy_q;
  assign done      = done_q;

  xfer_bus_seq_chk #(.N_REGS(N_REGS)) u_chk (
    .clk       (clk),
    .reset_n   (reset_n),
    .reg_write (reg_write_q),
    .reg_load  (reg_load_q),
    .inc       (inc_q),
    .dec       (dec_q),
    .ext_oe    (ext_oe_q),
    .busy      (busy_q),
    .done      (done_q)
  );

endmodule

// File: tb/tb_xfer_bus_seq.sv
// Scoreboard bench for xfer_bus_seq: each accepted command pushes its expected
// per-cycle output trace; a negedge monitor pops and compares every cycle.

module tb_xfer_bus_seq;

  localparam logic [1:0] OP_MOVE = 2'b00;
  localparam logic [1:0] OP_INC  = 2'b01;
  localparam logic [1:0] OP_DEC  = 2'b10;
  localparam logic [1:0] OP_LDX  = 2'b11;

  logic        clk;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [1:0]  cmd_src;
  logic [1:0]  cmd_dst;
  logic [3:0]  cmd_cnt;
  logic [15:0] cmd_data;
  logic [3:0]  reg_write;
  logic [3:0]  reg_load;
  logic [3:0]  inc;
  logic [3:0]  dec;
  logic        ext_oe;
  logic [15:0] ext_data;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  logic [19:0] sb[$];
  logic [15:0] exp_ext;

  xfer_bus_seq #(.N_REGS(4), .IDX_W(2)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_src   (cmd_src),
    .cmd_dst   (cmd_dst),
    .cmd_cnt   (cmd_cnt),
    .cmd_data  (cmd_data),
    .reg_write (reg_write),
    .reg_load  (reg_load),
    .inc       (inc),
    .dec       (dec),
    .ext_oe    (ext_oe),
    .ext_data  (ext_data),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [19:0] mk(input logic rdy, input logic bsy, input logic dn, input logic oe,
                                     input logic [3:0] rw, input logic [3:0] rl,
                                     input logic [3:0] in, input logic [3:0] de);
    return {rdy, bsy, dn, oe, rw, rl, in, de};
  endfunction

  function automatic logic [19:0] obs();
    return {cmd_ready, busy, done, ext_oe, reg_write, reg_load, inc, dec};
  endfunction

  function automatic logic [3:0] oh(input logic [1:0] idx);
    logic [3:0] one;
    one = 4'b0001;
    return one << idx;
  endfunction

  // Expected trace for the cycles after an accept, written from the command semantics
  task automatic push_exp(input logic [1:0] op, input logic [1:0] src, input logic [1:0] dst,
                          input logic [3:0] cnt);
    logic [3:0] s;
    logic [3:0] d;
    s = oh(src);
    d = oh(dst);
    case (op)
      OP_MOVE: begin
        if (src != dst) begin
          sb.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, s, 4'h0, 4'h0, 4'h0));
          sb.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, s, d, 4'h0, 4'h0));
        end
      end
      OP_LDX: begin
        sb.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0));
        sb.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 4'h0, d, 4'h0, 4'h0));
      end
      OP_INC: begin
        for (int i = 0; i <= int'(cnt); i++) sb.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, d, 4'h0));
      end
      default: begin
        for (int i = 0; i <= int'(cnt); i++) sb.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, d));
      end
    endcase
    sb.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0));
  endtask

  // Per-cycle monitor: compare against the scoreboard, check invariants, record new accepts
  always @(negedge clk) begin
    if (!reset_n) begin
      sb.delete();
      exp_ext = 16'h0000;
      check_val("rst_quiet", {busy, done, ext_oe, reg_write, reg_load, inc, dec}, 32'd0);
    end else begin
      if (sb.size() > 0) check_val("seq", obs(), sb.pop_front());
      else               check_val("idle", obs(), mk(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0));
      check_val("ext_data", ext_data, exp_ext);
      check_val("inv_drv", $onehot0({reg_write, ext_oe}), 1'b1);
      check_val("inv_load", $onehot0(reg_load), 1'b1);
      check_val("inv_incdec", (|inc) && (|dec), 1'b0);
      if (cmd_valid && cmd_ready) begin
        push_exp(cmd_op, cmd_src, cmd_dst, cmd_cnt);
        exp_ext = cmd_data;
      end
    end
  end

  task automatic wait_accept();
    int n;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      #1;
      if (cmd_ready && cmd_valid) break;
    end
    if (n >= 200) check_val("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [1:0] src, input logic [1:0] dst,
                       input logic [3:0] cnt, input logic [15:0] data);
    cmd_op    = op;
    cmd_src   = src;
    cmd_dst   = dst;
    cmd_cnt   = cnt;
    cmd_data  = data;
    cmd_valid = 1'b1;
    wait_accept();
  endtask

  task automatic drain();
    int n;
    cmd_valid = 1'b0;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      #1;
      if ((sb.size() == 0) && cmd_ready) break;
    end
    if (n >= 200) check_val("drain_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] r_op;
    logic [1:0] r_src;
    logic [1:0] r_dst;
    logic [3:0] r_cnt;
    logic [15:0] r_data;

    reset_n   = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = OP_MOVE;
    cmd_src   = 2'd0;
    cmd_dst   = 2'd0;
    cmd_cnt   = 4'd0;
    cmd_data  = 16'h0000;
    #1 reset_n = 1'b0;

    // Command held during reset: nothing happens until reset_n rises
    cmd_op    = OP_DEC;
    cmd_dst   = 2'd3;
    cmd_cnt   = 4'd0;
    cmd_data  = 16'h5A5A;
    cmd_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    #1 check_val("ready_after_rst", cmd_ready, 1'b1);
    wait_accept();
    drain();

    issue(OP_LDX, 2'd0, 2'd1, 4'd0, 16'hCAFE);
    drain();
    check_val("ldx_data", ext_data, 16'hCAFE);

    issue(OP_MOVE, 2'd1, 2'd2, 4'd0, 16'h1111);
    drain();
    issue(OP_MOVE, 2'd2, 2'd2, 4'd0, 16'h2222);
    drain();
    issue(OP_INC, 2'd0, 2'd0, 4'd4, 16'h3333);
    drain();

    // Back-to-back with cmd_valid held: second command must wait for DONE
    issue(OP_INC, 2'd0, 2'd1, 4'd2, 16'h4444);
    issue(OP_MOVE, 2'd3, 2'd0, 4'd0, 16'h5555);
    issue(OP_DEC, 2'd0, 2'd2, 4'd15, 16'h6666);
    drain();

    for (int k = 0; k < 8; k++) begin
      r_op   = 2'($urandom_range(0, 3));
      r_src  = 2'($urandom_range(0, 3));
      r_dst  = 2'($urandom_range(0, 3));
      r_cnt  = 4'($urandom_range(0, 15));
      r_data = 16'($urandom);
      issue(r_op, r_src, r_dst, r_cnt, r_data);
    end
    drain();

    // Reset in the middle of a long INC: strobes drop without waiting for a clock
    issue(OP_INC, 2'd0, 2'd2, 4'd15, 16'h7777);
    cmd_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 check_val("pre_rst_inc", inc, 4'b0100);
    reset_n = 1'b0;
    #1 check_val("async_drop", {busy, done, ext_oe, reg_write, reg_load, inc, dec}, 32'd0);
    check_val("rst_ready", cmd_ready, 1'b1);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    drain();

    issue(OP_MOVE, 2'd0, 2'd3, 4'd0, 16'h8888);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
